// File: rtl/pkt_readout_pkg.sv
// Shared definitions for the packet readout block: register map, CTRL bits and the FIFO entry.
package pkt_readout_pkg;

  localparam logic [2:0] REG_STATUS  = 3'd0;
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_DATA    = 3'd1;
  localparam logic [2:0] REG_META    = 3'd2;
  localparam logic [2:0] REG_PKT_CNT = 3'd3;
  localparam logic [2:0] REG_FILL    = 3'd4;

  localparam int unsigned CTRL_IRQ_EN = 0;

  localparam int unsigned EG_PORT_W = 2;

  typedef struct packed {
    logic                 sop;
    logic                 eop;
    logic [EG_PORT_W-1:0] port;
    logic [7:0]           data;
  } eg_entry_t;

  function automatic logic [7:0] sat8(input int unsigned v);
    return (v > 255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular buffer; full/empty are derived by the user from the fill count.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    fill
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    fill_q, fill_d;

  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign head = mem_q[rd_ptr_q];
  assign fill = fill_q;

endmodule

// File: rtl/pkt_readout.sv
// Buffers the switch egress byte stream and lets software read it back over Avalon-MM.
module pkt_readout
  import pkt_readout_pkg::*;
#(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned PORT_W = EG_PORT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [2:0]        address,
  input  logic [7:0]        writedata,
  output logic [7:0]        readdata,
  output logic              irq,
  input  logic              eg_valid,
  input  logic [7:0]        eg_data,
  input  logic              eg_sop,
  input  logic              eg_eop,
  input  logic [PORT_W-1:0] eg_port,
  output logic              eg_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  eg_entry_t         wr_entry, head_entry;
  logic [CW-1:0]     fill;
  logic              push, pop, rd, wr, empty, full;
  logic              head_sop, head_eop;
  logic [PORT_W-1:0] head_port;
  logic [7:0]        head_data;

  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          irq_en_q, irq_en_d;
  logic          irq_q, irq_d;
  logic [7:0]    readdata_q, readdata_d;

  assign empty    = (fill == '0);
  assign full     = (fill == CW'(DEPTH));
  assign eg_ready = ~full;
  assign push     = eg_valid & eg_ready;
  assign rd       = chipselect & read;
  assign wr       = chipselect & write;
  assign pop      = rd & (address == REG_DATA) & ~empty;

  assign wr_entry = '{sop: eg_sop, eop: eg_eop, port: eg_port, data: eg_data};

  sync_fifo #(
    .WIDTH ($bits(eg_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .head  (head_entry),
    .fill  (fill)
  );

  // Head fields read as zero when empty so stale RAM contents never leak out.
  assign head_sop  = head_entry.sop & ~empty;
  assign head_eop  = head_entry.eop & ~empty;
  assign head_port = empty ? '0 : head_entry.port;
  assign head_data = empty ? '0 : head_entry.data;

  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if ((push & eg_eop) && !(pop & head_eop)) begin
      pkt_cnt_d = pkt_cnt_q + 1'b1;
    end else if (!(push & eg_eop) && (pop & head_eop)) begin
      pkt_cnt_d = pkt_cnt_q - 1'b1;
    end

    irq_en_d = irq_en_q;
    if (wr && address == REG_CTRL) irq_en_d = writedata[CTRL_IRQ_EN];

    irq_d = irq_en_q & (pkt_cnt_d != '0);

    readdata_d = readdata_q;
    if (rd) begin
      case (address)
        REG_STATUS:  readdata_d = {4'b0, pkt_cnt_q != '0, head_sop, full, empty};
        REG_DATA:    readdata_d = head_data;
        REG_META:    readdata_d = {head_sop, head_eop, {(6 - PORT_W){1'b0}}, head_port};
        REG_PKT_CNT: readdata_d = sat8(32'(pkt_cnt_q));
        REG_FILL:    readdata_d = sat8(32'(fill));
        default:     readdata_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_cnt_q  <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      readdata_q <= 8'h00;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pkt_readout.sv
// Directed bench for pkt_readout: register reads, packet flow, back-pressure, wrap and reset.
module tb_pkt_readout;

  logic       clk = 1'b0;
  logic       reset;
  logic       chipselect, read, write;
  logic [2:0] address;
  logic [7:0] writedata, readdata;
  logic       irq;
  logic       eg_valid, eg_sop, eg_eop, eg_ready;
  logic [7:0] eg_data;
  logic [1:0] eg_port;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pkt_readout #(
    .DEPTH  (64),
    .PORT_W (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .eg_valid   (eg_valid),
    .eg_data    (eg_data),
    .eg_sop     (eg_sop),
    .eg_eop     (eg_eop),
    .eg_port    (eg_port),
    .eg_ready   (eg_ready)
  );

  typedef struct {
    logic [2:0] addr;
    logic [7:0] exp;
    string      name;
  } rd_vec_t;

  rd_vec_t vecs [13];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
    end
  endtask

  // All drive/sample points sit 1ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    d = readdata;
  endtask

  task automatic read_check(input logic [2:0] a, input logic [7:0] exp, input string name);
    logic [7:0] d;
    bus_read(a, d);
    check(name, d, exp);
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] d, input logic s, input logic e, input logic [1:0] p);
    int n = 0;
    eg_valid = 1'b1; eg_data = d; eg_sop = s; eg_eop = e; eg_port = p;
    while (!eg_ready && n < 200) begin
      tick();
      n++;
    end
    if (n == 200) begin
      errors++; checks++;
      $display("FAIL push_timeout: eg_ready stuck at 0, expected 1");
    end
    tick();
    eg_valid = 1'b0; eg_sop = 1'b0; eg_eop = 1'b0;
  endtask

  task automatic do_reset();
    eg_valid = 1'b0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask

  logic [7:0] q [$];
  logic [7:0] d;

  initial begin
    vecs[0]  = '{3'd0, 8'h01, "rst_status"};
    vecs[1]  = '{3'd3, 8'h00, "rst_pkt_cnt"};
    vecs[2]  = '{3'd6, 8'h00, "unused_addr"};
    vecs[3]  = '{3'd3, 8'h01, "pkt_cnt_1"};
    vecs[4]  = '{3'd4, 8'h03, "fill_3"};
    vecs[5]  = '{3'd0, 8'h0C, "status_pkt"};
    vecs[6]  = '{3'd2, 8'h82, "meta_sop_p2"};
    vecs[7]  = '{3'd1, 8'hAA, "data_aa"};
    vecs[8]  = '{3'd1, 8'hBB, "data_bb"};
    vecs[9]  = '{3'd1, 8'hCC, "data_cc"};
    vecs[10] = '{3'd0, 8'h01, "status_drained"};
    vecs[11] = '{3'd3, 8'h00, "pkt_cnt_0"};
    vecs[12] = '{3'd2, 8'h00, "meta_empty"};

    address = '0; writedata = '0; eg_data = '0; eg_sop = 0; eg_eop = 0; eg_port = '0;
    do_reset();

    check("rst_eg_ready", {7'b0, eg_ready}, 8'h01);
    check("rst_irq", {7'b0, irq}, 8'h00);
    for (int i = 0; i < 3; i++) read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);

    push_byte(8'hAA, 1'b1, 1'b0, 2'd2);
    push_byte(8'hBB, 1'b0, 1'b0, 2'd2);
    push_byte(8'hCC, 1'b0, 1'b1, 2'd2);
    for (int i = 3; i < 13; i++) read_check(vecs[i].addr, vecs[i].exp, vecs[i].name);

    // Interrupt follows complete-packet presence.
    bus_write(3'd0, 8'h01);
    check("irq_before_push", {7'b0, irq}, 8'h00);
    push_byte(8'h5A, 1'b1, 1'b1, 2'd0);
    check("irq_after_push", {7'b0, irq}, 8'h01);
    read_check(3'd1, 8'h5A, "data_5a");
    check("irq_after_pop", {7'b0, irq}, 8'h00);

    // Fill to capacity, hold a 65th byte upstream, then release it with one pop.
    for (int i = 1; i <= 64; i++) push_byte(8'(i), 1'b0, 1'b0, 2'd1);
    check("full_eg_ready", {7'b0, eg_ready}, 8'h00);
    read_check(3'd0, 8'h02, "status_full");
    eg_valid = 1'b1; eg_data = 8'hEE; eg_port = 2'd1;
    repeat (2) tick();
    check("held_eg_ready", {7'b0, eg_ready}, 8'h00);
    read_check(3'd4, 8'h40, "fill_64");
    read_check(3'd1, 8'h01, "pop_when_full");
    check("ready_after_pop", {7'b0, eg_ready}, 8'h01);
    tick();
    eg_valid = 1'b0;
    read_check(3'd4, 8'h40, "fill_after_held");
    for (int i = 2; i <= 64; i++) read_check(3'd1, 8'(i), "drain_order");
    read_check(3'd1, 8'hEE, "drain_held");
    read_check(3'd0, 8'h01, "status_after_drain");

    // Simultaneous push and pop at fill=10, long enough to wrap the pointers.
    q.delete();
    for (int i = 0; i < 10; i++) begin
      push_byte(8'h10 + 8'(i), 1'b0, 1'b0, 2'd3);
      q.push_back(8'h10 + 8'(i));
    end
    for (int k = 0; k < 70; k++) begin
      eg_valid = 1'b1; eg_data = 8'h40 + 8'(k); eg_sop = 1'b0; eg_eop = 1'b0;
      chipselect = 1'b1; read = 1'b1; address = 3'd1;
      tick();
      check("steady_order", readdata, q.pop_front());
      q.push_back(8'h40 + 8'(k));
    end
    eg_valid = 1'b0; chipselect = 1'b0; read = 1'b0;
    read_check(3'd4, 8'h0A, "steady_fill");
    while (q.size() > 0) read_check(3'd1, q.pop_front(), "steady_drain");

    // Reset mid-packet with one complete packet buffered and irq asserted.
    bus_write(3'd0, 8'hFF);
    push_byte(8'h11, 1'b1, 1'b1, 2'd0);
    push_byte(8'h22, 1'b1, 1'b0, 2'd1);
    push_byte(8'h33, 1'b0, 1'b0, 2'd1);
    push_byte(8'h44, 1'b0, 1'b0, 2'd1);
    push_byte(8'h55, 1'b0, 1'b0, 2'd1);
    check("irq_pre_reset", {7'b0, irq}, 8'h01);
    read_check(3'd4, 8'h05, "fill_5");
    do_reset();
    check("irq_post_reset", {7'b0, irq}, 8'h00);
    check("ready_post_reset", {7'b0, eg_ready}, 8'h01);
    read_check(3'd0, 8'h01, "status_post_reset");
    read_check(3'd3, 8'h00, "pkt_cnt_post_reset");
    read_check(3'd1, 8'h00, "data_empty");
    read_check(3'd4, 8'h00, "fill_after_empty_read");
    push_byte(8'h77, 1'b1, 1'b1, 2'd0);
    check("irq_en_cleared", {7'b0, irq}, 8'h00);
    read_check(3'd1, 8'h77, "data_after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
